// File: rtl/beat_tone_player.sv
// Plays one decaying square-wave tone burst per beat event; the intensity sets
// the pitch and the start amplitude. Emits a signed 8-bit sample and a 1-bit tone.
module beat_tone_player #(
  parameter int unsigned HALF_P0    = 56818,
  parameter int unsigned HALF_P1    = 45455,
  parameter int unsigned HALF_P2    = 37922,
  parameter int unsigned HALF_P3    = 28409,
  parameter int unsigned HP_W       = 17,
  parameter int unsigned BURST_HP   = 64,
  parameter int unsigned GAP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat_en,
  input  logic [1:0] beat_intensity,
  output logic [7:0] audio_sample,
  output logic       tone_out,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int unsigned HL_W  = (BURST_HP > 1) ? $clog2(BURST_HP) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HL_W-1:0]  HL_INIT  = HL_W'(BURST_HP - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DECAY, GAP} state_t;

  state_t            r_state;
  logic              r_beat_d;
  logic              r_armed;
  logic [1:0]        r_int;
  logic [6:0]        r_amp;
  logic              r_pos;
  logic [HP_W-1:0]   r_hp_cnt;
  logic [HL_W-1:0]   r_hp_left;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [7:0]        r_drop;

  logic              w_evt;
  logic              w_start;
  logic              w_drop;
  logic              w_active;
  logic [7:0]        w_mag;

  function automatic logic [HP_W-1:0] half_m1(input logic [1:0] sel);
    case (sel)
      2'd0:    half_m1 = HP_W'(HALF_P0 - 1);
      2'd1:    half_m1 = HP_W'(HALF_P1 - 1);
      2'd2:    half_m1 = HP_W'(HALF_P2 - 1);
      default: half_m1 = HP_W'(HALF_P3 - 1);
    endcase
  endfunction

  function automatic logic [6:0] amp_of(input logic [1:0] sel);
    case (sel)
      2'd0:    amp_of = 7'd32;
      2'd1:    amp_of = 7'd64;
      2'd2:    amp_of = 7'd96;
      default: amp_of = 7'd127;
    endcase
  endfunction

  // r_armed only rises once beat_en has been seen low after reset, so a level
  // still held high across reset release cannot look like a fresh edge.
  always_comb begin
    w_evt   = beat_en & ~r_beat_d & r_armed;
    w_start = 1'b0;
    case (r_state)
      IDLE:    w_start = w_evt;
      PLAY:    w_start = w_evt && (beat_intensity > r_int);
      DECAY:   w_start = w_evt;
      default: w_start = 1'b0;
    endcase
    w_drop = w_evt & ~w_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_beat_d  <= 1'b0;
      r_armed   <= 1'b0;
      r_int     <= '0;
      r_amp     <= '0;
      r_pos     <= 1'b0;
      r_hp_cnt  <= '0;
      r_hp_left <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_beat_d <= beat_en;
      r_armed  <= r_armed | ~beat_en;
      if (w_start) begin
        r_int     <= beat_intensity;
        r_amp     <= amp_of(beat_intensity);
        r_pos     <= 1'b1;
        r_hp_cnt  <= half_m1(beat_intensity);
        r_hp_left <= HL_INIT;
        r_state   <= PLAY;
      end else begin
        case (r_state)
          PLAY: begin
            if (r_hp_cnt == '0) begin
              r_pos    <= ~r_pos;
              r_hp_cnt <= half_m1(r_int);
              if (r_hp_left == '0) begin
                r_amp   <= r_amp >> 1;
                r_state <= DECAY;
              end else begin
                r_hp_left <= r_hp_left - 1'b1;
              end
            end else begin
              r_hp_cnt <= r_hp_cnt - 1'b1;
            end
          end
          DECAY: begin
            if (r_hp_cnt == '0) begin
              r_pos    <= ~r_pos;
              r_hp_cnt <= half_m1(r_int);
              r_amp    <= r_amp >> 1;
              if ((r_amp >> 1) == '0) begin
                r_gap_cnt <= GAP_INIT;
                r_state   <= GAP;
              end
            end else begin
              r_hp_cnt <= r_hp_cnt - 1'b1;
            end
          end
          GAP: begin
            if (r_gap_cnt == '0) r_state <= IDLE;
            else                 r_gap_cnt <= r_gap_cnt - 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end

  always_comb begin
    w_active     = (r_state == PLAY) || (r_state == DECAY);
    w_mag        = {1'b0, r_amp};
    busy         = (r_state != IDLE);
    tone_out     = w_active & r_pos;
    audio_sample = '0;
    if (w_active) audio_sample = r_pos ? w_mag : (~w_mag + 8'd1);
    drop_cnt     = r_drop;
  end

endmodule

// File: tb/tb_beat_tone_player.sv
// Directed bench for beat_tone_player with small half-periods, a 4 half-period
// burst and a 10-cycle gap.
module tb_beat_tone_player;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       beat_en = 1'b0;
  logic [1:0] beat_intensity = 2'd0;
  logic [7:0] audio_sample;
  logic       tone_out;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  beat_tone_player #(
    .HALF_P0(5), .HALF_P1(4), .HALF_P2(3), .HALF_P3(2),
    .BURST_HP(4), .GAP_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .beat_en(beat_en), .beat_intensity(beat_intensity),
    .audio_sample(audio_sample), .tone_out(tone_out), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] intensity);
    beat_en = 1'b1;
    beat_intensity = intensity;
    tick();
    beat_en = 1'b0;
  endtask

  task automatic do_reset;
    beat_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    beat_en = 1'b0;
    #3;
    n_checks++; if (audio_sample !== 8'd0) begin n_fail++; $display("FAIL reset_audio got %0d want 0", audio_sample); end
    n_checks++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL reset_tone got %b want 0", tone_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_beat;
    int a;
    bit pos;
    logic [7:0] exp_s;
    do_reset();
    pulse(2'd0);
    for (int k = 0; k < 55; k++) begin
      if (k < 20)      a = 32;
      else if (k < 45) a = 16 >> ((k - 20) / 5);
      else             a = 0;
      pos = ((k / 5) % 2) == 0;
      exp_s = pos ? 8'(a) : 8'(-a);
      n_checks++; if (audio_sample !== exp_s) begin n_fail++; $display("FAIL single_audio k=%0d got %0d want %0d", k, $signed(audio_sample), $signed(exp_s)); end
      n_checks++; if (tone_out !== ((a != 0) && pos)) begin n_fail++; $display("FAIL single_tone k=%0d got %b want %b", k, tone_out, (a != 0) && pos); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy k=%0d got %b want 1", k, busy); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL single_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_held_level;
    do_reset();
    beat_en = 1'b1;
    beat_intensity = 2'd1;
    tick();
    n_checks++; if (audio_sample !== 8'd64) begin n_fail++; $display("FAIL held_start got %0d want 64", $signed(audio_sample)); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        n_checks++; if (audio_sample !== 8'hC0) begin n_fail++; $display("FAIL held_neg got %0d want -64", $signed(audio_sample)); end
      end
    end
    beat_en = 1'b0;
    for (int k = 6; k <= 16; k++) tick();
    n_checks++; if (audio_sample !== 8'd32) begin n_fail++; $display("FAIL held_decay got %0d want 32", $signed(audio_sample)); end
    for (int k = 17; k <= 49; k++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_busy_end got %b want 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_idle got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL held_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_play_restart;
    do_reset();
    pulse(2'd0);
    for (int k = 0; k < 4; k++) tick();
    pulse(2'd3);
    n_checks++; if (audio_sample !== 8'd127) begin n_fail++; $display("FAIL restart_amp got %0d want 127", $signed(audio_sample)); end
    tick();
    n_checks++; if (audio_sample !== 8'd127) begin n_fail++; $display("FAIL restart_k1 got %0d want 127", $signed(audio_sample)); end
    pulse(2'd1);
    n_checks++; if (audio_sample !== 8'h81) begin n_fail++; $display("FAIL lower_k2 got %0d want -127", $signed(audio_sample)); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL lower_drop got %0d want 1", drop_cnt); end
    tick();
    tick();
    n_checks++; if (audio_sample !== 8'd127) begin n_fail++; $display("FAIL restart_k4 got %0d want 127", $signed(audio_sample)); end
    pulse(2'd3);
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL equal_drop got %0d want 2", drop_cnt); end
    tick();
    n_checks++; if (audio_sample !== 8'h81) begin n_fail++; $display("FAIL equal_k6 got %0d want -127", $signed(audio_sample)); end
  endtask

  task automatic test_gap_and_decay;
    do_reset();
    pulse(2'd0);
    for (int k = 0; k < 45; k++) tick();
    n_checks++; if (busy !== 1'b1 || audio_sample !== 8'd0) begin n_fail++; $display("FAIL gap_entry busy=%b audio=%0d want 1/0", busy, audio_sample); end
    pulse(2'd2);
    n_checks++; if (busy !== 1'b1 || audio_sample !== 8'd0) begin n_fail++; $display("FAIL gap_event busy=%b audio=%0d want 1/0", busy, audio_sample); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_drop got %0d want 1", drop_cnt); end
    for (int k = 46; k < 54; k++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_last got %b want 1", busy); end
    pulse(2'd1);
    n_checks++; if (busy !== 1'b0 || audio_sample !== 8'd0) begin n_fail++; $display("FAIL gap_end busy=%b audio=%0d want 0/0", busy, audio_sample); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL gap_end_drop got %0d want 2", drop_cnt); end
    tick();
    pulse(2'd3);
    for (int k = 0; k < 8; k++) tick();
    n_checks++; if (audio_sample !== 8'd63) begin n_fail++; $display("FAIL decay_amp got %0d want 63", $signed(audio_sample)); end
    tick();
    pulse(2'd0);
    n_checks++; if (audio_sample !== 8'd32) begin n_fail++; $display("FAIL decay_restart got %0d want 32", $signed(audio_sample)); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL decay_drop got %0d want 2", drop_cnt); end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int r = 1; r <= 60; r++) begin
      pulse(2'd0);
      for (int k = 0; k < 45; k++) tick();
      for (int j = 0; j < 5; j++) begin
        pulse(2'd1);
        tick();
      end
      if (r == 50) begin
        n_checks++; if (drop_cnt !== 8'd250) begin n_fail++; $display("FAIL sat_250 got %0d want 250", drop_cnt); end
      end
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", drop_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle got %b want 0", busy); end
  endtask

  task automatic test_async_reset;
    do_reset();
    pulse(2'd0);
    tick();
    pulse(2'd0);
    n_checks++; if (drop_cnt !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset drop=%0d busy=%b want 1/1", drop_cnt, busy); end
    beat_en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (audio_sample !== 8'd0 || tone_out !== 1'b0) begin n_fail++; $display("FAIL async_out audio=%0d tone=%b want 0/0", audio_sample, tone_out); end
    n_checks++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL async_state busy=%b drop=%0d want 0/0", busy, drop_cnt); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_after_reset k=%0d busy=%b want 0", k, busy); end
    end
    beat_en = 1'b0;
    tick();
    beat_en = 1'b1;
    tick();
    n_checks++; if (audio_sample !== 8'd32 || busy !== 1'b1) begin n_fail++; $display("FAIL fresh_edge audio=%0d busy=%b want 32/1", $signed(audio_sample), busy); end
    beat_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_held_level();
    test_play_restart();
    test_gap_and_decay();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
